// File: rtl/video_writer.sv
// Command-driven word writer feeding the display engine's video memory port.
// Latency: first write one cycle after command acceptance, then one word per cycle.
// Backpressure: cmd_ready low during multi-word ops except on the final word cycle.
module video_writer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 15,
   parameter int WORDS  = 19200
) (
   input  logic              CLK_CPU,
   input  logic              RESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [ADDR_W-1:0] cmd_count,
   output logic              busy,
   output logic              video_write_enable,
   output logic [ADDR_W-1:0] video_write_addr,
   output logic [DATA_W-1:0] video_write_data
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_FILL  = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
   localparam logic [ADDR_W:0]   WORDS_CNT = (ADDR_W + 1)'(WORDS);
   localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W + 1)'(1);

   // addr_q is the address of the next word to emit; remaining_q counts the
   // word currently on the output plus those still to come.
   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [ADDR_W:0]     remaining_q, remaining_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   wa_q, wa_d;
   logic [DATA_W-1:0]   wd_q, wd_d;

   logic                accept;
   logic                start_vld;
   logic [ADDR_W-1:0]   start_addr;
   logic [ADDR_W:0]     start_cnt;

   // Framebuffer address successor, wrapping at the end of the frame.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
   endfunction

   assign cmd_ready          = (state_q == IDLE) || (remaining_q == ONE_CNT);
   assign busy               = (state_q == RUN) && (remaining_q > ONE_CNT);
   assign accept             = cmd_valid && cmd_ready;
   assign video_write_enable = we_q;
   assign video_write_addr   = wa_q;
   assign video_write_data   = wd_q;

   // Decode an accepted command into a start address and word count.
   always_comb begin
      start_vld  = 1'b0;
      start_addr = cmd_addr;
      start_cnt  = ONE_CNT;
      if (accept) begin
         case (cmd_op)
            OP_WRITE: start_vld = 1'b1;
            OP_FILL: begin
               start_vld = (cmd_count != '0);
               start_cnt = {1'b0, cmd_count};
            end
            OP_CLEAR: begin
               start_vld  = 1'b1;
               start_addr = '0;
               start_cnt  = WORDS_CNT;
            end
            default: start_vld = 1'b0;
         endcase
      end
   end

   // Next-state and registered output computation.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      remaining_d = remaining_q;
      we_d        = 1'b0;
      wa_d        = wa_q;
      wd_d        = wd_q;
      if ((state_q == RUN) && (remaining_q > ONE_CNT)) begin
         we_d        = 1'b1;
         wa_d        = addr_q;
         wd_d        = data_q;
         addr_d      = next_addr(addr_q);
         remaining_d = remaining_q - ONE_CNT;
      end else begin
         // Idle, or the last word is on the output: a new command may start here.
         state_d     = IDLE;
         remaining_d = '0;
         if (start_vld) begin
            state_d     = RUN;
            we_d        = 1'b1;
            wa_d        = start_addr;
            wd_d        = cmd_data;
            data_d      = cmd_data;
            addr_d      = next_addr(start_addr);
            remaining_d = start_cnt;
         end
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge CLK_CPU or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         remaining_q <= '0;
         we_q        <= 1'b0;
         wa_q        <= '0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         remaining_q <= remaining_d;
         we_q        <= we_d;
         wa_q        <= wa_d;
         wd_q        <= wd_d;
      end
   end

endmodule

// File: tb/tb_video_writer.sv
// Directed bench for video_writer: vector table plus multi-cycle sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected values are hand-computed constants in the table and sequences.
module tb_video_writer;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [14:0] cmd_addr;
   logic [15:0] cmd_data;
   logic [14:0] cmd_count;
   logic        busy;
   logic        vwe;
   logic [14:0] vwa;
   logic [15:0] vwd;

   int checks = 0;
   int passed = 0;

   video_writer dut (
      .CLK_CPU            (clk),
      .RESET              (rst),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_op             (cmd_op),
      .cmd_addr           (cmd_addr),
      .cmd_data           (cmd_data),
      .cmd_count          (cmd_count),
      .busy               (busy),
      .video_write_enable (vwe),
      .video_write_addr   (vwa),
      .video_write_data   (vwd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [14:0] addr;
      logic [15:0] data;
      logic [14:0] count;
      int          n;
      int          e0, e1, e2, e3;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic int pick(input vec_t v, input int i);
      case (i)
         0: return v.e0;
         1: return v.e1;
         2: return v.e2;
         default: return v.e3;
      endcase
   endfunction

   // Called just after a falling edge; returns just after a falling edge.
   task automatic run_vec(input vec_t v, input int idx);
      cmd_op    = v.op;
      cmd_addr  = v.addr;
      cmd_data  = v.data;
      cmd_count = v.count;
      cmd_valid = 1'b1;
      chk($sformatf("v%0d_ready_pre", idx), 32'(cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      if (v.n == 0) begin
         chk($sformatf("v%0d_en_none", idx), 32'(vwe), 32'd0);
         chk($sformatf("v%0d_ready_none", idx), 32'(cmd_ready), 32'd1);
         chk($sformatf("v%0d_busy_none", idx), 32'(busy), 32'd0);
      end else begin
         for (int i = 0; i < v.n; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("v%0d_en_w%0d", idx, i), 32'(vwe), 32'd1);
            chk($sformatf("v%0d_addr_w%0d", idx, i), 32'(vwa), 32'(pick(v, i)));
            chk($sformatf("v%0d_data_w%0d", idx, i), 32'(vwd), 32'(v.data));
            chk($sformatf("v%0d_ready_w%0d", idx, i), 32'(cmd_ready), (i == v.n - 1) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_busy_w%0d", idx, i), 32'(busy), (i < v.n - 1) ? 32'd1 : 32'd0);
         end
      end
      @(negedge clk);
      chk($sformatf("v%0d_en_after", idx), 32'(vwe), 32'd0);
      chk($sformatf("v%0d_ready_after", idx), 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      int bad;

      //          op     addr      data      count  n  e0     e1     e2 e3
      vecs[0] = '{2'b00, 15'd5,     16'hA5A5, 15'd0, 1, 5,     0,     0, 0};
      vecs[1] = '{2'b01, 15'd19198, 16'hFFFF, 15'd4, 4, 19198, 19199, 0, 1};
      vecs[2] = '{2'b01, 15'd100,   16'h1111, 15'd0, 0, 0,     0,     0, 0};
      vecs[3] = '{2'b11, 15'd7,     16'h2222, 15'd9, 0, 0,     0,     0, 0};
      vecs[4] = '{2'b01, 15'd10,    16'h1234, 15'd3, 3, 10,    11,    12, 0};
      vecs[5] = '{2'b00, 15'h7FFF,  16'h0F0F, 15'd0, 1, 32767, 0,     0, 0};

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_addr  = '0;
      cmd_data  = '0;
      cmd_count = '0;
      #1;
      chk("rst_en", 32'(vwe), 32'd0);
      chk("rst_addr", 32'(vwa), 32'd0);
      chk("rst_data", 32'(vwd), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

      // Three back-to-back WRITEs with valid held high.
      for (int i = 0; i < 3; i++) begin
         cmd_op    = 2'b00;
         cmd_addr  = 15'(i + 1);
         cmd_data  = 16'(16'h1000 + i);
         cmd_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("b2b_en_%0d", i), 32'(vwe), 32'd1);
         chk($sformatf("b2b_addr_%0d", i), 32'(vwa), 32'(i + 1));
         chk($sformatf("b2b_data_%0d", i), 32'(vwd), 32'(16'h1000 + i));
         chk($sformatf("b2b_ready_%0d", i), 32'(cmd_ready), 32'd1);
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("b2b_en_after", 32'(vwe), 32'd0);

      // CLEAR with a WRITE waiting on valid for the last-word cycle.
      cmd_op    = 2'b10;
      cmd_addr  = 15'd77;
      cmd_count = 15'd3;
      cmd_data  = 16'h0000;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_op   = 2'b00;
      cmd_addr = 15'h0020;
      cmd_data = 16'hBEEF;
      bad = 0;
      for (int i = 0; i < 19200; i++) begin
         if (i > 0) @(negedge clk);
         if (vwe !== 1'b1 || vwa !== 15'(i) || vwd !== 16'h0000) bad++;
         if (cmd_ready !== ((i == 19199) ? 1'b1 : 1'b0)) bad++;
         if (busy !== ((i < 19199) ? 1'b1 : 1'b0)) bad++;
      end
      chk("clear_bad_words", 32'(bad), 32'd0);
      chk("clear_last_addr", 32'(vwa), 32'd19199);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("queued_en", 32'(vwe), 32'd1);
      chk("queued_addr", 32'(vwa), 32'h20);
      chk("queued_data", 32'(vwd), 32'hBEEF);
      @(negedge clk);
      chk("queued_en_after", 32'(vwe), 32'd0);

      // CLEAR interrupted by reset after 100 writes.
      cmd_op    = 2'b10;
      cmd_data  = 16'h5555;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (99) @(negedge clk);
      chk("mid_addr", 32'(vwa), 32'd99);
      chk("mid_en", 32'(vwe), 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_en", 32'(vwe), 32'd0);
      chk("arst_addr", 32'(vwa), 32'd0);
      chk("arst_data", 32'(vwd), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (vwe !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) bad++;
      end
      chk("post_rst_idle", 32'(bad), 32'd0);
      run_vec(vecs[0], 6);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/video_writer.md
# video_writer

Command-driven producer for the display engine's video memory write port (`video_write_enable` / `video_write_data` / `video_write_addr`), running in the CPU clock domain. It accepts single-word writes, span fills and full-screen clears from the CPU-side command interface, then emits one framebuffer word write per cycle. It sits between the CPU store path and `display_engine`. The frame is 640x480 monochrome, packed 16 pixels per word.

## Interface
Parameters:
- `DATA_W`, default 16: bits per video memory word (pixels per word).
- `ADDR_W`, default 15: video memory word address width.
- `WORDS`, default 19200: number of framebuffer words (640*480/16); valid addresses are 0..WORDS-1.

Ports:
- `CLK_CPU`  in  1  the single clock; all logic on its rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_op`  in  2  00 WRITE, 01 FILL, 10 CLEAR, 11 reserved.
- `cmd_addr`  in  ADDR_W  start word address (WRITE/FILL).
- `cmd_data`  in  DATA_W  word or fill pattern.
- `cmd_count`  in  ADDR_W  word count (FILL only).
- `busy`  out  1  a multi-word operation is in progress.
- `video_write_enable`  out  1  write strobe to `display_engine`.
- `video_write_addr`  out  ADDR_W  write word address.
- `video_write_data`  out  DATA_W  write word.

## Operation
- Reset values: `video_write_enable`=0, `video_write_addr`=0, `video_write_data`=0, `busy`=0, `cmd_ready`=1, state IDLE.
- A command is accepted on a rising edge where `cmd_valid && cmd_ready`. Command fields are sampled only at acceptance.
- State machine has two states, IDLE and RUN. It holds registered `addr`, `data` and `remaining` (ADDR_W+1 bits).
- WRITE: one write at `cmd_addr` with `cmd_data`. An address >= WORDS is forwarded unchanged; the display engine ignores it.
- FILL: `cmd_count` writes of `cmd_data` starting at `cmd_addr`. The address increments by 1 per write and wraps from WORDS-1 to 0. If `cmd_count`=0, the command is accepted and no write is emitted.
- CLEAR: WORDS writes of `cmd_data` at addresses 0..WORDS-1. `cmd_addr` and `cmd_count` are ignored.
- Reserved op (11): accepted, no write, no state change.
- In RUN, each cycle outputs one word (`video_write_enable`=1) and decrements `remaining`. The state returns to IDLE after the last word unless a new command is accepted in that same cycle.
- `cmd_ready` = (state==IDLE) || (remaining==1), which allows back-to-back commands with no gap.
- `busy`=1 while in RUN and `remaining` > 1.
- Outputs are registered. `video_write_enable` is 0 in every cycle with no word to emit. Addr/data hold their last values when enable is 0.

## Timing
- Command accepted at edge k: the first write is visible in cycle k+1, so latency is 1 cycle.
- An N-word command drives enable high in cycles k+1..k+N. `cmd_ready` is low in k+1..k+N-1 and high in k+N.
- Back-to-back WRITEs sustain one write per cycle.
- A command accepted in the last-word cycle of the previous one produces its first word in the next cycle, with no bubble.
- CLEAR takes exactly WORDS cycles (19200 by default).
- Wrap case: FILL at `cmd_addr`=WORDS-2 with count 4 writes addresses WORDS-2, WORDS-1, 0, 1.
- When a count-0 FILL or reserved op is accepted while idle, enable stays 0 next cycle and `cmd_ready` stays 1.
- `RESET` asserted mid-operation forces all outputs to reset values immediately (asynchronously). The remaining words are dropped, and after release the block is IDLE.
- `cmd_valid` while `cmd_ready`=0 has no effect. The requester holds the command.

## Test plan
- Reset, then WRITE addr=0x0005 data=0xA5A5 -> exactly one cycle of enable=1 with addr 0x0005 and data 0xA5A5, one cycle after acceptance; `cmd_ready` stays 1.
- Three back-to-back WRITEs to addrs 1, 2, 3 -> enable high three consecutive cycles with matching addr/data, no gaps.
- FILL addr=19198 count=4 data=0xFFFF -> writes to 19198, 19199, 0, 1. `cmd_ready` low for 3 cycles and high on the 4th write cycle. `busy` is high for the first 3 write cycles.
- CLEAR data=0x0000 -> 19200 consecutive writes at addrs 0..19199. A WRITE queued on `cmd_valid` is accepted on the last-word cycle and appears immediately after.
- FILL count=0 and op=11 -> accepted, enable never asserts, `cmd_ready` stays 1.
- CLEAR started, `RESET` pulsed after 100 writes -> enable drops to 0 asynchronously and stays 0 after release. A following WRITE behaves as after a fresh reset.
